// File: rtl/register_file_mp.sv
// Multi-port register file: N_READ combinational read ports, two write ports,
// optional same-cycle write forwarding, optional hard-wired zero entry, and a
// post-reset clear sequencer that zeroes every entry before raising ready.
module register_file_mp #(
  parameter int W             = 32,
  parameter int W_reg_address = 5,
  parameter int N_READ        = 3,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_READ*W_reg_address-1:0] A_rd,
  output logic [N_READ*W-1:0]             RD,
  input  logic [W_reg_address-1:0]        A3,
  input  logic                            WE3,
  input  logic [W-1:0]                    WD3,
  input  logic [W_reg_address-1:0]        A4,
  input  logic                            WE4,
  input  logic [W-1:0]                    WD4,
  output logic                            ready,
  output logic                            wr_conflict
);

  localparam int DEPTH = 2 ** W_reg_address;
  localparam logic [W_reg_address-1:0] ADDR_ZERO = {W_reg_address{1'b0}};
  localparam logic [W_reg_address-1:0] ADDR_LAST = {W_reg_address{1'b1}};
  localparam logic [W_reg_address-1:0] CNT_STEP  = {{(W_reg_address-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]             DATA_ZERO = {W{1'b0}};

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [W_reg_address-1:0] cnt;
  logic [W-1:0]             mem [DEPTH];

  logic                     run;
  logic                     clear_last;
  logic                     we3_ok;
  logic                     we4_ok;
  logic                     collision;
  logic [W_reg_address-1:0] rd_addr;
  logic [W-1:0]             rd_word;

  // Qualify write requests: writes only count in RUN, and entry 0 is protected when hard-wired.
  always_comb begin
    run        = (state == RUN);
    clear_last = (cnt == ADDR_LAST);
    collision  = run & WE3 & WE4 & (A3 == A4);
    we3_ok     = run & WE3 & ~((ZERO_REG != 0) && (A3 == ADDR_ZERO));
    we4_ok     = run & WE4 & ~((ZERO_REG != 0) && (A4 == ADDR_ZERO));
  end

  // Next-state logic: CLEAR walks every entry once, then RUN holds until reset.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: begin
        if (clear_last) begin
          state_next = RUN;
        end else begin
          state_next = CLEAR;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // State, clear counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CLEAR;
      cnt         <= ADDR_ZERO;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      state       <= state_next;
      ready       <= (state_next == RUN);
      wr_conflict <= collision;
      if (state == CLEAR) begin
        cnt <= cnt + CNT_STEP;
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Storage update: clear target in CLEAR, otherwise port 0 then port 1 so port 1 wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        mem[cnt] <= DATA_ZERO;
      end
      if (we3_ok) begin
        mem[A3] <= WD3;
      end
      if (we4_ok) begin
        mem[A4] <= WD4;
      end
    end
  end

  // Combinational read ports with zero-entry masking and same-cycle forwarding (port 1 first).
  always_comb begin
    RD      = {(N_READ*W){1'b0}};
    rd_addr = ADDR_ZERO;
    rd_word = DATA_ZERO;
    for (int i = 0; i < N_READ; i++) begin
      rd_addr = A_rd[i*W_reg_address +: W_reg_address];
      if (!run) begin
        rd_word = DATA_ZERO;
      end else if ((ZERO_REG != 0) && (rd_addr == ADDR_ZERO)) begin
        rd_word = DATA_ZERO;
      end else if ((BYPASS != 0) && WE4 && (A4 == rd_addr)) begin
        rd_word = WD4;
      end else if ((BYPASS != 0) && WE3 && (A3 == rd_addr)) begin
        rd_word = WD3;
      end else begin
        rd_word = mem[rd_addr];
      end
      RD[i*W +: W] = rd_word;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (default parameters).
// A behavioural model tracks the clear phase and contents; one negedge process
// compares every output against it, and directed scenarios pin literal values.
module tb_register_file_mp;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  a_rd;
  logic [NR*W-1:0]   rd;
  logic [AW-1:0]     a3;
  logic              we3;
  logic [W-1:0]      wd3;
  logic [AW-1:0]     a4;
  logic              we4;
  logic [W-1:0]      wd4;
  logic              ready;
  logic              wr_conflict;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  register_file_mp dut (
    .clk         (clk),
    .rst         (rst),
    .A_rd        (a_rd),
    .RD          (rd),
    .A3          (a3),
    .WE3         (we3),
    .WD3         (wd3),
    .A4          (a4),
    .WE4         (we4),
    .WD4         (wd4),
    .ready       (ready),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem [32];
  int           m_cleared;
  bit           m_ready;
  bit           m_conf;

  always @(negedge rst) begin
    m_cleared = 0;
    m_ready   = 1'b0;
    m_conf    = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (!m_ready) begin
        m_mem[m_cleared] = 32'h0;
        m_cleared        = m_cleared + 1;
        m_ready          = (m_cleared == 32);
        m_conf           = 1'b0;
      end else begin
        m_conf = we3 && we4 && (a3 == a4);
        if (we3 && a3 != 5'd0) m_mem[a3] = wd3;
        if (we4 && a4 != 5'd0) m_mem[a4] = wd4;
      end
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (!rst || !m_ready) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we4 && a4 == a) return wd4;
    if (we3 && a3 == a) return wd3;
    return m_mem[a];
  endfunction

  function automatic logic [W-1:0] rdp(input int p);
    return rd[p*W +: W];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", {31'h0, ready}, {31'h0, m_ready});
      chk("model_wr_conflict", {31'h0, wr_conflict}, {31'h0, m_conf});
      for (int p = 0; p < NR; p++) begin
        chk("model_rd", rdp(p), exp_rd(a_rd[p*AW +: AW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ports(input logic [AW-1:0] p0, input logic [AW-1:0] p1, input logic [AW-1:0] p2);
    a_rd = {p2, p1, p0};
  endtask

  task automatic count_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    a_rd = '0;
    a3 = 5'd0; we3 = 1'b0; wd3 = 32'h0;
    a4 = 5'd0; we4 = 1'b0; wd4 = 32'h0;
    #3;
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_wr_conflict", {31'h0, wr_conflict}, 32'h0);

    // 1: release, count edges to ready, writes during CLEAR ignored
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000DEAD;
    rst = 1'b1;
    count_ready(n);
    we3 = 1'b0;
    chk("ready_edges", n, 32'd32);
    for (int a = 0; a < 32; a++) begin
      set_ports(5'(a), 5'(a), 5'(31 - a));
      @(negedge clk);
      chk("cleared_entry", rdp(0), 32'h0);
      tick();
    end
    set_ports(5'd5, 5'd5, 5'd5);
    @(negedge clk);
    chk("entry5_after_clear", rdp(0), 32'h0);

    // 2: two independent writes on the same edge
    tick();
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h11111111;
    we4 = 1'b1; a4 = 5'd9; wd4 = 32'h22222222;
    set_ports(5'd7, 5'd9, 5'd8);
    tick();
    we3 = 1'b0; we4 = 1'b0;
    @(negedge clk);
    chk("rd7", rdp(0), 32'h11111111);
    chk("rd9", rdp(1), 32'h22222222);
    chk("no_conflict", {31'h0, wr_conflict}, 32'h0);

    // 3: collision on address 4, port 1 wins, one-cycle flag
    tick();
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'hAAAA0000;
    we4 = 1'b1; a4 = 5'd4; wd4 = 32'h5555FFFF;
    set_ports(5'd4, 5'd4, 5'd7);
    @(negedge clk);
    chk("collision_bypass", rdp(0), 32'h5555FFFF);
    tick();
    we3 = 1'b0; we4 = 1'b0;
    @(negedge clk);
    chk("entry4", rdp(0), 32'h5555FFFF);
    chk("conflict_pulse", {31'h0, wr_conflict}, 32'h1);
    tick();
    @(negedge clk);
    chk("conflict_clears", {31'h0, wr_conflict}, 32'h0);

    // 4: writes to x0 discarded, even when forwarded
    tick();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
    set_ports(5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("x0_same_cycle", rdp(0), 32'h0);
    tick();
    we3 = 1'b0;
    @(negedge clk);
    chk("x0_after", rdp(0), 32'h0);

    // 5: bypass to all three ports
    tick();
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h1;
    tick();
    wd3 = 32'h77;
    set_ports(5'd3, 5'd3, 5'd3);
    @(negedge clk);
    chk("bypass_p0", rdp(0), 32'h77);
    chk("bypass_p1", rdp(1), 32'h77);
    chk("bypass_p2", rdp(2), 32'h77);
    tick();
    we3 = 1'b0;
    @(negedge clk);
    chk("entry3_after", rdp(2), 32'h77);

    // Mixed traffic sweep, checked by the model every cycle
    for (int i = 1; i <= 20; i++) begin
      tick();
      we3 = 1'b1; a3 = 5'(i); wd3 = 32'h01010101 * i;
      we4 = (i % 3 == 0);
      a4  = (i % 6 == 0) ? 5'(i) : 5'((i + 7) % 32);
      wd4 = ~(32'h01010101 * i);
      set_ports(5'(i), 5'((i + 7) % 32), 5'(i - 1));
    end
    tick();
    we3 = 1'b0; we4 = 1'b0;
    set_ports(5'd6, 5'd12, 5'd13);
    @(negedge clk);
    chk("sweep_entry6", rdp(0), ~(32'h01010101 * 6));
    chk("sweep_entry12", rdp(1), ~(32'h01010101 * 12));

    // 6: reset in RUN, then reset again at clear count 10
    tick();
    rst = 1'b0;
    tick();
    chk("rerun_ready_low", {31'h0, ready}, 32'h0);
    rst = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    count_ready(n);
    chk("ready_edges_after_abort", n, 32'd32);
    set_ports(5'd7, 5'd9, 5'd4);
    @(negedge clk);
    chk("recleared_entry7", rdp(0), 32'h0);
    chk("recleared_entry4", rdp(2), 32'h0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
